// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one request/ack RAM bus between instruction fetch and data access.
// Optional MEM_ARB_TIMEOUT_EN: abort a transaction with bus_err_o after TIMEOUT_CYCLES cycles without ack.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inst_ce_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    output logic [DATA_WIDTH-1:0] inst_rdata_o,
    output logic                  inst_valid_o,
    input  logic                  data_request_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_op_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_valid_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [3:0]            bus_op_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic                  bus_err_o,
    output logic                  stallreq_o
);

    typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

    state_t state;
    logic   data_go;
    logic   inst_go;
    logic   expire;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
        end
    endgenerate

    // A requester whose completion pulse is high is still holding its request; mask it.
    assign data_go    = data_request_i & ~data_valid_o;
    assign inst_go    = inst_ce_i & ~inst_valid_o;
    assign stallreq_o = data_go | inst_go;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            tmo_cnt <= 8'd0;
        else if (state == IDLE)
            tmo_cnt <= 8'd0;
        else if (!bus_ack_i)
            tmo_cnt <= tmo_cnt + 8'd1;
    end

    // Ack in the expiry cycle takes precedence, so expiry requires no ack.
    assign expire = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) && !bus_ack_i;
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            inst_rdata_o <= '0;
            inst_valid_o <= 1'b0;
            data_rdata_o <= '0;
            data_valid_o <= 1'b0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_op_o     <= 4'd0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= '0;
            bus_err_o    <= 1'b0;
        end else begin
            inst_valid_o <= 1'b0;
            data_valid_o <= 1'b0;
            bus_err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_go) begin
                        state       <= DATA;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= data_we_i;
                        bus_op_o    <= data_op_i;
                        bus_addr_o  <= data_addr_i;
                        bus_wdata_o <= data_wdata_i;
                    end else if (inst_go) begin
                        state       <= INST;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_op_o    <= 4'd0;
                        bus_addr_o  <= inst_addr_i;
                        bus_wdata_o <= '0;
                    end
                end
                INST: begin
                    if (bus_ack_i) begin
                        state        <= IDLE;
                        bus_req_o    <= 1'b0;
                        inst_rdata_o <= bus_rdata_i;
                        inst_valid_o <= 1'b1;
                    end else if (expire) begin
                        state        <= IDLE;
                        bus_req_o    <= 1'b0;
                        inst_rdata_o <= '0;
                        inst_valid_o <= 1'b1;
                        bus_err_o    <= 1'b1;
                    end
                end
                DATA: begin
                    if (bus_ack_i) begin
                        state        <= IDLE;
                        bus_req_o    <= 1'b0;
                        data_valid_o <= 1'b1;
                        if (!bus_we_o)
                            data_rdata_o <= bus_rdata_i;
                    end else if (expire) begin
                        state        <= IDLE;
                        bus_req_o    <= 1'b0;
                        data_rdata_o <= '0;
                        data_valid_o <= 1'b1;
                        bus_err_o    <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table of inputs/expected outputs plus reset and timeout sequences.
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        inst_ce_i = 1'b0;
    logic [31:0] inst_addr_i = '0;
    logic [31:0] inst_rdata_o;
    logic        inst_valid_o;
    logic        data_request_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_op_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic [31:0] data_rdata_o;
    logic        data_valid_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_op_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        bus_err_o;
    logic        stallreq_o;

    int nchk = 0;
    int nfail = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i),
        .inst_rdata_o(inst_rdata_o), .inst_valid_o(inst_valid_o),
        .data_request_i(data_request_i), .data_we_i(data_we_i), .data_op_i(data_op_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_valid_o(data_valid_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_op_o(bus_op_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .bus_err_o(bus_err_o), .stallreq_o(stallreq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ice;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [3:0]  dop;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] brdata;
        logic        back;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ewe;
        logic [3:0]  eop;
        logic [31:0] ewdata;
        logic        eiv;
        logic [31:0] eird;
        logic        edv;
        logic [31:0] edrd;
        logic        estall;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        inst_ce_i      = v.ice;
        inst_addr_i    = v.iaddr;
        data_request_i = v.dreq;
        data_we_i      = v.dwe;
        data_op_i      = v.dop;
        data_addr_i    = v.daddr;
        data_wdata_i   = v.dwdata;
        bus_rdata_i    = v.brdata;
        bus_ack_i      = v.back;
    endtask

    task automatic idle_inputs();
        inst_ce_i = 0; inst_addr_i = 0; data_request_i = 0; data_we_i = 0;
        data_op_i = 0; data_addr_i = 0; data_wdata_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    endtask

    initial begin
        // ice iaddr dreq dwe dop daddr dwdata brdata back | ereq eaddr ewe eop ewdata eiv eird edv edrd estall
        // fetch alone, held through valid (re-issue mask), then a new fetch at 0x88
        vec[0]  = '{1, 32'h80, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,   0, 0, 0, 0, 1};
        vec[1]  = '{1, 32'h80, 0, 0, 0, 0, 0, 32'h13, 1,       1, 32'h80, 0, 0, 0, 0, 0, 0, 0, 1};
        vec[2]  = '{1, 32'h80, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,   1, 32'h13, 0, 0, 0};
        vec[3]  = '{1, 32'h88, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0,   0, 32'h13, 0, 0, 1};
        vec[4]  = '{1, 32'h88, 0, 0, 0, 0, 0, 32'h93, 1,       1, 32'h88, 0, 0, 0, 0, 32'h13, 0, 0, 1};
        vec[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0,   1, 32'h93, 0, 0, 0};
        // simultaneous load + fetch; stray ack while IDLE in cycle 8
        vec[6]  = '{1, 32'h84, 1, 0, 4, 32'h1000, 0, 0, 0,     0, 0, 0, 0, 0,   0, 32'h93, 0, 0, 1};
        vec[7]  = '{1, 32'h84, 1, 0, 4, 32'h1000, 0, 32'hDEADBEEF, 1,
                    1, 32'h1000, 0, 4, 0, 0, 32'h93, 0, 0, 1};
        vec[8]  = '{1, 32'h84, 1, 0, 4, 32'h1000, 0, 32'hFFFFFFFF, 1,
                    0, 0, 0, 0, 0, 0, 32'h93, 1, 32'hDEADBEEF, 1};
        vec[9]  = '{1, 32'h84, 0, 0, 0, 0, 0, 32'h00100073, 1,
                    1, 32'h84, 0, 0, 0, 0, 32'h93, 0, 32'hDEADBEEF, 1};
        vec[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 1, 32'h00100073, 0, 32'hDEADBEEF, 0};
        // store with 3 wait states
        vec[11] = '{0, 0, 1, 1, 2, 32'h2000, 32'h12345678, 0, 0,
                    0, 0, 0, 0, 0, 0, 32'h00100073, 0, 32'hDEADBEEF, 1};
        for (int k = 12; k < 15; k++)
            vec[k] = '{0, 0, 1, 1, 2, 32'h2000, 32'h12345678, 0, 0,
                       1, 32'h2000, 1, 2, 32'h12345678, 0, 32'h00100073, 0, 32'hDEADBEEF, 1};
        vec[15] = '{0, 0, 1, 1, 2, 32'h2000, 32'h12345678, 32'hCAFEF00D, 1,
                    1, 32'h2000, 1, 2, 32'h12345678, 0, 32'h00100073, 0, 32'hDEADBEEF, 1};
        vec[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 32'h00100073, 1, 32'hDEADBEEF, 0};
        vec[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 32'h00100073, 0, 32'hDEADBEEF, 0};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_bus_req", -1, 32'(bus_req_o), 0);
        chk("rst_bus_addr", -1, bus_addr_o, 0);
        chk("rst_bus_wdata", -1, bus_wdata_o, 0);
        chk("rst_bus_we_op", -1, {27'd0, bus_we_o, bus_op_o}, 0);
        chk("rst_valids", -1, {30'd0, inst_valid_o, data_valid_o}, 0);
        chk("rst_rdata", -1, inst_rdata_o | data_rdata_o, 0);
        chk("rst_err_stall", -1, {30'd0, bus_err_o, stallreq_o}, 0);

        for (int k = 0; k < NV; k++) begin
            @(posedge clk_i); #1;
            drive(vec[k]);
            @(negedge clk_i);
            chk("bus_req", k, 32'(bus_req_o), 32'(vec[k].ereq));
            if (vec[k].ereq) begin
                chk("bus_addr", k, bus_addr_o, vec[k].eaddr);
                chk("bus_we", k, 32'(bus_we_o), 32'(vec[k].ewe));
                chk("bus_op", k, 32'(bus_op_o), 32'(vec[k].eop));
                chk("bus_wdata", k, bus_wdata_o, vec[k].ewdata);
            end
            chk("inst_valid", k, 32'(inst_valid_o), 32'(vec[k].eiv));
            chk("inst_rdata", k, inst_rdata_o, vec[k].eird);
            chk("data_valid", k, 32'(data_valid_o), 32'(vec[k].edv));
            chk("data_rdata", k, data_rdata_o, vec[k].edrd);
            chk("stallreq", k, 32'(stallreq_o), 32'(vec[k].estall));
            chk("bus_err", k, 32'(bus_err_o), 0);
        end

        // reset in the second wait cycle of a load, then a late ack
        @(posedge clk_i); #1;
        idle_inputs();
        data_request_i = 1; data_addr_i = 32'h3000; data_op_i = 4'h4;
        @(posedge clk_i); #1;
        chk("rstmid_req_w1", 100, 32'(bus_req_o), 1);
        @(posedge clk_i); #1;
        chk("rstmid_req_w2", 101, 32'(bus_req_o), 1);
        #2 rst_i = 1'b1;
        data_request_i = 0;
        #1;
        chk("rstmid_req", 101, 32'(bus_req_o), 0);
        chk("rstmid_addr", 101, bus_addr_o, 0);
        chk("rstmid_rdata", 101, inst_rdata_o | data_rdata_o, 0);
        chk("rstmid_op", 101, 32'(bus_op_o), 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        bus_ack_i = 1; bus_rdata_i = 32'h55;
        @(negedge clk_i);
        chk("late_ack_req", 103, 32'(bus_req_o), 0);
        @(posedge clk_i); #1;
        bus_ack_i = 0;
        @(negedge clk_i);
        chk("late_ack_dvalid", 104, 32'(data_valid_o), 0);
        chk("late_ack_drdata", 104, data_rdata_o, 0);

`ifdef MEM_ARB_TIMEOUT_EN
        // load a known value so the forced-zero rdata is visible
        @(posedge clk_i); #1;
        data_request_i = 1; data_addr_i = 32'h4000;
        @(posedge clk_i); #1;
        bus_ack_i = 1; bus_rdata_i = 32'hA5A5A5A5;
        @(posedge clk_i); #1;
        bus_ack_i = 0; data_request_i = 0;
        chk("tmo_pre_rdata", 200, data_rdata_o, 32'hA5A5A5A5);
        // RAM never acks
        @(posedge clk_i); #1;
        data_request_i = 1; data_addr_i = 32'h4004;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i); #1;
            chk("tmo_req", 210 + c, 32'(bus_req_o), 1);
            chk("tmo_no_err", 210 + c, 32'(bus_err_o), 0);
        end
        @(posedge clk_i); #1;
        chk("tmo_req_drop", 214, 32'(bus_req_o), 0);
        chk("tmo_dvalid", 214, 32'(data_valid_o), 1);
        chk("tmo_err", 214, 32'(bus_err_o), 1);
        chk("tmo_rdata", 214, data_rdata_o, 0);
        data_request_i = 0;
        @(posedge clk_i); #1;
        chk("tmo_err_pulse", 215, {30'd0, bus_err_o, data_valid_o}, 0);
        chk("tmo_idle", 215, 32'(bus_req_o), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port RAM bus between the instruction-fetch requester (pc_reg/if stage) and the data requester (mem stage).
- Fixed priority: data wins over fetch. One transaction in flight at a time.
- Downstream bus uses a request/ack handshake, so RAM latency may vary.
- While any requester is waiting, stallreq_o asks pipe_ctrl to hold the pipeline.

Parameters:
- ADDR_WIDTH, 32, width of instruction, data and bus addresses.
- DATA_WIDTH, 32, width of read/write data.
- TIMEOUT_CYCLES, 255, cycles without ack before abort; used only with MEM_ARB_TIMEOUT_EN; legal range 1..255.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- inst_ce_i  in  1  fetch request; held until inst_valid_o.
- inst_addr_i  in  ADDR_WIDTH  fetch address.
- inst_rdata_o  out  DATA_WIDTH  fetched instruction.
- inst_valid_o  out  1  one-cycle pulse: fetch complete.
- data_request_i  in  1  load/store request; held until data_valid_o.
- data_we_i  in  1  1 = store.
- data_op_i  in  4  access size/sign code; passed through unchanged.
- data_addr_i  in  ADDR_WIDTH  data address.
- data_wdata_i  in  DATA_WIDTH  store data.
- data_rdata_o  out  DATA_WIDTH  load data.
- data_valid_o  out  1  one-cycle pulse: load/store complete.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write enable.
- bus_op_o  out  4  bus op code.
- bus_addr_o  out  ADDR_WIDTH  bus address.
- bus_wdata_o  out  DATA_WIDTH  bus write data.
- bus_rdata_i  in  DATA_WIDTH  bus read data; valid when bus_ack_i = 1.
- bus_ack_i  in  1  bus completion, single cycle.
- bus_err_o  out  1  one-cycle timeout pulse; constant 0 without the feature.
- stallreq_o  out  1  stall request to pipe_ctrl.

Behaviour:
- Reset: state IDLE; all registered outputs 0 (rdata_o, valid_o, bus_* outputs, bus_err_o); timeout counter 0.
- Reset mid-transaction abandons it. An ack arriving later while in IDLE is ignored.
- States: IDLE, INST, DATA.
- IDLE, choosing a requester:
  - A request whose own valid_o is high this cycle is masked, so it is not re-issued.
  - If data_request_i is active (after masking): latch we/op/addr/wdata, go to DATA.
  - Else if inst_ce_i is active (after masking): latch addr, go to INST. bus_we_o = 0, bus_op_o = 4'b0 for fetches.
  - Else stay in IDLE.
  - If both are active, data is chosen; fetch is served in the next IDLE cycle.
- bus_req_o = 1 in INST and DATA. bus_* outputs come from the latched values, so the bus is stable for the whole transaction.
- When bus_ack_i = 1 in INST or DATA:
  - Next edge: go to IDLE.
  - Capture bus_rdata_i into inst_rdata_o (INST) or data_rdata_o (DATA, loads only).
  - Pulse the matching valid_o for 1 cycle.
- Stores: data_rdata_o holds its previous value; data_valid_o still pulses.
- Latency with 0-wait RAM (ack in the first bus_req_o cycle): request at cycle N, bus_req_o at N+1, valid_o at N+2.
- Back-to-back transactions: a new request can be accepted in the valid_o cycle. Minimum spacing is 2 cycles per transaction.
- rdata_o values hold until the next capture.
- bus_ack_i in IDLE is ignored.
- stallreq_o is combinational: (data_request_i & ~data_valid_o) | (inst_ce_i & ~inst_valid_o).
- Requesters must hold their inputs stable from assertion until their valid_o pulse. A change while pending is not detected; it is a protocol error.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entry to INST/DATA and increments each cycle without ack.
  - When count = TIMEOUT_CYCLES - 1 with no ack: go to IDLE and drop bus_req_o.
  - Pulse the matching valid_o and bus_err_o together; the matching rdata_o is forced to 0.
  - An ack in the same cycle as expiry wins: normal completion, no error.
- Undefined: no counter; the arbiter waits indefinitely for ack; bus_err_o tied 0.

Test Plan:
- Fetch alone: inst_ce_i = 1, addr 0x80, RAM acks at the first req cycle with 0x00000013 → bus_req_o at cycle 1, inst_valid_o at cycle 2 with inst_rdata_o = 0x00000013, stallreq_o 1 in cycles 0–1 and 0 in cycle 2.
- Simultaneous requests: load at 0x1000 (RAM returns 0xDEADBEEF) and fetch at 0x84, both at cycle 0 → data transaction first, data_valid_o at cycle 2 with 0xDEADBEEF. Fetch goes on the bus at cycle 3; inst_valid_o at cycle 4.
- Store with 3 wait states: we = 1, addr 0x2000, wdata 0x12345678, op 4'h2 → bus_* stable for 4 req cycles, data_valid_o 1 cycle after ack, data_rdata_o unchanged.
- Re-issue masking: fetch stays asserted through its valid cycle → no second bus_req_o starts in that cycle. The next fetch (new address presented after valid_o) starts one cycle later.
- Reset mid-transaction: rst_i asserted in the 2nd wait cycle of a load → all outputs 0 immediately. A later bus_ack_i gives no valid_o pulse.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4: RAM never acks → bus_req_o high for 4 cycles, then data_valid_o = bus_err_o = 1 for one cycle, data_rdata_o = 0, state IDLE.
